// File: rtl/fetch_cycle_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: the fetch FSM state
//   encoding and the default widths / constants that the fetch_cycle top and
//   its IF/ID register take as parameter defaults.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

  // Default fetch/PC width, instruction width and PC step.
  localparam int FETCH_PC_W    = 9;
  localparam int FETCH_INSTR_W = 33;
  localparam int FETCH_PC_INC  = 4;

  // Encoding placed on InstrD when IF/ID holds a bubble.
  localparam logic [FETCH_INSTR_W-1:0] FETCH_NOP_INSTR = '0;

  // S_REQ   : nothing outstanding, issue a request at PCF.
  // S_WAIT  : one request outstanding, waiting for its response.
  // S_HOLD  : response captured in the hold buffer while decode is stalled.
  // S_DRAIN : the outstanding response belongs to a redirected-away path.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetchState_t;

endpackage

// File: rtl/Mux2Parametrizado.sv
// -----------------------------------------------------------------------------
// Mux2Parametrizado
//   Generic two-input multiplexer of configurable width.
//   Ports:
//     d0  in  WIDTH  selected when s = 0
//     d1  in  WIDTH  selected when s = 1
//     s   in  1      select
//     y   out WIDTH  result
// -----------------------------------------------------------------------------
module Mux2Parametrizado #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/fetch_cycle_if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
//   IF/ID pipeline register between fetch and decode. Three behaviours per
//   edge, in priority order: bubble (invalidate, drive NOP, keep PC fields),
//   load (take a new instruction), otherwise hold.
//   Ports:
//     clk        in  1        clock, rising edge
//     rst        in  1        asynchronous active-low reset
//     load       in  1        capture instrIn/pcIn/pcPlus4In, mark valid
//     bubble     in  1        invalidate the slot (wins over load)
//     instrIn    in  INSTR_W  instruction to load
//     pcIn       in  PC_W     PC of instrIn
//     pcPlus4In  in  PC_W     pcIn + PC_INC, already wrapped
//     InstrD     out INSTR_W  registered instruction (NOP_INSTR when bubble)
//     PCD        out PC_W     registered PC
//     PCPlus4D   out PC_W     registered PC + PC_INC
//     ValidD     out 1        1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_id_register
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = FETCH_PC_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [PC_W-1:0]    pcIn,
  input  logic [PC_W-1:0]    pcPlus4In,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  // A bubble leaves PCD/PCPlus4D untouched so downstream debug/trace still
  // sees the last real PC; only the valid bit and instruction word change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (bubble) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
    end else if (load) begin
      ValidD   <= 1'b1;
      InstrD   <= instrIn;
      PCD      <= pcIn;
      PCPlus4D <= pcPlus4In;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// -----------------------------------------------------------------------------
// fetch_cycle
//   Instruction-fetch stage. Owns the fetch PC, runs a one-outstanding
//   request/response handshake with instruction memory (latency >= 1) and
//   drives the IF/ID register consumed by decode. Honours hazard-unit stalls
//   and EX-stage redirects; every IF/ID slot that does not carry a fresh
//   instruction is marked invalid so decode never sees a duplicate.
//   Ports:
//     clk         in  1        clock, rising edge
//     rst         in  1        asynchronous active-low reset
//     StallF      in  1        hold IF/ID, accept no new instruction
//     FlushD      in  1        bubble into IF/ID at the next edge
//     PCSrcE      in  1        redirect request from EX
//     PCTargetE   in  PC_W     redirect address
//     imem_req    out 1        request strobe (combinational)
//     imem_addr   out PC_W     request address
//     imem_valid  in  1        response strobe
//     imem_rdata  in  INSTR_W  response instruction
//     InstrD      out INSTR_W  IF/ID instruction
//     PCD         out PC_W     PC of InstrD
//     PCPlus4D    out PC_W     PCD + PC_INC, wrapped
//     ValidD      out 1        1 = InstrD is real, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_cycle
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = FETCH_PC_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter int                 PC_INC    = FETCH_PC_INC,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  fetchState_t        state;
  fetchState_t        stateNext;

  logic [PC_W-1:0]    PCF;        // next address to request
  logic [PC_W-1:0]    reqPC;      // address of the outstanding request
  logic [PC_W-1:0]    holdPC;     // hold buffer: PC
  logic [INSTR_W-1:0] holdInstr;  // hold buffer: instruction

  logic [PC_W-1:0]    pcIncF;
  logic [PC_W-1:0]    pcNextF;
  logic [PC_W-1:0]    loadPC;
  logic [PC_W-1:0]    loadPCPlus4;
  logic [INSTR_W-1:0] loadInstr;

  logic               issue;      // a request goes out this cycle
  logic               capture;    // response goes to the hold buffer
  logic               loadSrc;    // IF/ID takes a new instruction
  logic               fromHold;   // ... and it comes from the hold buffer
  logic               idBubble;

  // Next-PC select: sequential increment or the EX redirect target.
  assign pcIncF = PCF + PC_STEP;

  Mux2Parametrizado #(
    .WIDTH (PC_W)
  ) uNextPcMux (
    .d0 (pcIncF),
    .d1 (PCTargetE),
    .s  (PCSrcE),
    .y  (pcNextF)
  );

  // Fetch control: next state, request strobe and IF/ID source select.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    capture   = 1'b0;
    loadSrc   = 1'b0;
    fromHold  = 1'b0;

    case (state)
      S_REQ: begin
        issue     = 1'b1;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          if (StallF) begin
            capture   = 1'b1;
            stateNext = S_HOLD;
          end else begin
            // Response accepted and the next request overlaps it.
            loadSrc   = 1'b1;
            issue     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          loadSrc   = 1'b1;
          fromHold  = 1'b1;
          issue     = 1'b1;
          stateNext = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (imem_valid) begin
          stateNext = S_REQ;
        end
      end
      default: stateNext = S_REQ;
    endcase

    // A redirect overrides everything: no request, no load, no capture.
    // Leaving S_HOLD discards the buffered instruction. If a response is
    // still in flight it has to be drained before the target is requested.
    if (PCSrcE) begin
      issue   = 1'b0;
      capture = 1'b0;
      loadSrc = 1'b0;
      if ((state == S_WAIT || state == S_DRAIN) && !imem_valid) begin
        stateNext = S_DRAIN;
      end else begin
        stateNext = S_REQ;
      end
    end
  end

  // The state register resets to S_REQ asynchronously, so the strobe is
  // qualified with rst to stay low for the whole reset window.
  assign imem_req  = issue & rst;
  assign imem_addr = PCF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
      PCF   <= RESET_PC;
    end else begin
      state <= stateNext;
      if (issue || PCSrcE) begin
        PCF <= pcNextF;
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when they are read.
  always_ff @(posedge clk) begin
    if (issue) begin
      reqPC <= PCF;
    end
    if (capture) begin
      holdInstr <= imem_rdata;
      holdPC    <= reqPC;
    end
  end

  assign loadInstr   = fromHold ? holdInstr : imem_rdata;
  assign loadPC      = fromHold ? holdPC    : reqPC;
  assign loadPCPlus4 = loadPC + PC_STEP;

  // When decode is not stalled and nothing new arrives, the slot must be
  // invalidated; holding a valid instruction would let decode take it twice.
  assign idBubble = PCSrcE | FlushD | (~StallF & ~loadSrc);

  if_id_register #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) uIfId (
    .clk       (clk),
    .rst       (rst),
    .load      (loadSrc),
    .bubble    (idBubble),
    .instrIn   (loadInstr),
    .pcIn      (loadPC),
    .pcPlus4In (loadPCPlus4),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

endmodule

// File: tb/tb_fetch_cycle.sv
// -----------------------------------------------------------------------------
// tb_fetch_cycle
//   Self-checking bench for fetch_cycle. A behavioural instruction memory
//   answers each request after a chosen latency with a word derived from the
//   address. A stream-level reference tracks the next address that should be
//   requested and the next PC decode should consume (sequential, restarting
//   at the target on a redirect); decode consumes IF/ID on every cycle that
//   is neither stalled nor redirected.
// -----------------------------------------------------------------------------
module tb_fetch_cycle;

  localparam int                 PC_W     = 9;
  localparam int                 INSTR_W  = 33;
  localparam int                 PC_INC   = 4;
  localparam logic [PC_W-1:0]    RESET_PC = 9'h000;
  localparam logic [INSTR_W-1:0] NOP      = 33'h0;

  logic               clk = 1'b0;
  logic               rst;
  logic               StallF;
  logic               FlushD;
  logic               PCSrcE;
  logic [PC_W-1:0]    PCTargetE;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] InstrD;
  logic [PC_W-1:0]    PCD;
  logic [PC_W-1:0]    PCPlus4D;
  logic               ValidD;

  fetch_cycle #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .PC_INC    (PC_INC),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // memory model state
  int              cyc;
  bit              outst;
  int              due;
  logic [PC_W-1:0] pendAddr;
  int              latMin = 1;
  int              latMax = 1;

  // stream reference
  logic [PC_W-1:0] expReq;
  logic [PC_W-1:0] expPC;
  int              delivered = 0;

  // samples of the last cycle
  logic               sReq;
  logic               sValid;
  logic [PC_W-1:0]    sAddr;
  logic [PC_W-1:0]    sPCD;
  logic [PC_W-1:0]    sPCPlus4;
  logic [INSTR_W-1:0] sInstr;

  function automatic logic [INSTR_W-1:0] memWord(input logic [PC_W-1:0] a);
    logic [23:0] h;
    h = ({15'd0, a} * 24'd40503) ^ 24'hA5C3E1;
    return {a, h};
  endfunction

  function automatic logic [PC_W-1:0] wrapAdd(input logic [PC_W-1:0] a);
    int s;
    s = (int'(a) + PC_INC) % (1 << PC_W);
    return PC_W'(s);
  endfunction

  function automatic bit respDue();
    return outst && (cyc == due);
  endfunction

  task automatic modelReset();
    cyc    = 0;
    outst  = 1'b0;
    due    = 0;
    expReq = RESET_PC;
    expPC  = RESET_PC;
  endtask

  // One clock cycle. Entered just after a falling edge; drives inputs,
  // samples #1 later, checks against the reference, returns at the next
  // falling edge.
  task automatic cycle(input bit stall, input bit redir,
                       input logic [PC_W-1:0] tgt, input bit flush);
    bit v;
    v          = respDue();
    imem_valid = v;
    imem_rdata = v ? memWord(pendAddr) : INSTR_W'({$urandom, $urandom});
    StallF     = stall;
    PCSrcE     = redir;
    PCTargetE  = tgt;
    FlushD     = flush;
    #1;
    sReq     = imem_req;
    sAddr    = imem_addr;
    sValid   = ValidD;
    sPCD     = PCD;
    sPCPlus4 = PCPlus4D;
    sInstr   = InstrD;

    if (redir) begin
      checks++;
      if (sReq !== 1'b0) begin
        failures++;
        $display("FAIL redirect_gate: imem_req=%b required 0 (cycle %0d)", sReq, cyc);
      end
    end
    if (sReq === 1'b1) begin
      checks++;
      if (sAddr !== expReq) begin
        failures++;
        $display("FAIL req_addr: got %h required %h (cycle %0d)", sAddr, expReq, cyc);
      end
      checks++;
      if (outst && !v) begin
        failures++;
        $display("FAIL req_overlap: request at %h while %h outstanding (cycle %0d)", sAddr, pendAddr, cyc);
      end
      expReq = wrapAdd(sAddr);
    end
    if (redir) expReq = tgt;

    if (sValid === 1'b0) begin
      checks++;
      if (sInstr !== NOP) begin
        failures++;
        $display("FAIL bubble_instr: InstrD=%h required %h (cycle %0d)", sInstr, NOP, cyc);
      end
    end
    if (redir) begin
      expPC = tgt;
    end else if (!stall && sValid === 1'b1) begin
      checks++;
      if (sPCD !== expPC) begin
        failures++;
        $display("FAIL consume_pc: PCD=%h required %h (cycle %0d)", sPCD, expPC, cyc);
        expPC = sPCD;
      end
      checks++;
      if (sInstr !== memWord(expPC)) begin
        failures++;
        $display("FAIL consume_instr: InstrD=%h required %h (cycle %0d)", sInstr, memWord(expPC), cyc);
      end
      checks++;
      if (sPCPlus4 !== wrapAdd(expPC)) begin
        failures++;
        $display("FAIL consume_pcplus4: PCPlus4D=%h required %h (cycle %0d)", sPCPlus4, wrapAdd(expPC), cyc);
      end
      expPC = wrapAdd(expPC);
      delivered++;
    end

    if (v) outst = 1'b0;
    if (sReq === 1'b1) begin
      outst    = 1'b1;
      due      = cyc + int'($urandom_range(latMax, latMin));
      pendAddr = sAddr;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    StallF     = 1'b0;
    FlushD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ValidD !== 1'b0)   begin failures++; $display("FAIL reset_valid: %b required 0", ValidD); end
    checks++; if (InstrD !== NOP)    begin failures++; $display("FAIL reset_instr: %h required %h", InstrD, NOP); end
    checks++; if (PCD !== 9'h000)    begin failures++; $display("FAIL reset_pcd: %h required 000", PCD); end
    checks++; if (PCPlus4D !== 9'h0) begin failures++; $display("FAIL reset_pcplus4: %h required 000", PCPlus4D); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: %b required 0", imem_req); end
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_stream();
    int d0;
    latMin = 1; latMax = 1;
    cycle(0, 0, '0, 0);
    checks++; if (sReq !== 1'b1 || sAddr !== RESET_PC) begin failures++; $display("FAIL first_req: req=%b addr=%h required 1/%h", sReq, sAddr, RESET_PC); end
    checks++; if (sValid !== 1'b0) begin failures++; $display("FAIL first_valid0: ValidD=%b required 0", sValid); end
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b0) begin failures++; $display("FAIL first_valid1: ValidD=%b required 0", sValid); end
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b1 || sPCD !== 9'h000 || sPCPlus4 !== 9'h004) begin
      failures++; $display("FAIL first_instr: valid=%b PCD=%h PCPlus4D=%h required 1/000/004", sValid, sPCD, sPCPlus4);
    end
    cycle(0, 0, '0, 0);
    checks++; if (sPCD !== 9'h004) begin failures++; $display("FAIL second_instr: PCD=%h required 004", sPCD); end
    cycle(0, 0, '0, 0);
    checks++; if (sPCD !== 9'h008) begin failures++; $display("FAIL third_instr: PCD=%h required 008", sPCD); end
    d0 = delivered;
    repeat (10) cycle(0, 0, 9'(($urandom)), 0);
    checks++; if (delivered - d0 != 10) begin failures++; $display("FAIL throughput: %0d in 10 cycles required 10", delivered - d0); end
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] prevPC, heldPC;
    latMin = 1; latMax = 1;
    cycle(0, 0, '0, 0);
    prevPC = sPCD;
    cycle(1, 0, '0, 0);
    heldPC = sPCD;
    checks++; if (heldPC !== wrapAdd(prevPC) || sValid !== 1'b1) begin failures++; $display("FAIL stall_entry: PCD=%h required %h", heldPC, wrapAdd(prevPC)); end
    checks++; if (sReq !== 1'b0) begin failures++; $display("FAIL stall_req0: imem_req=%b required 0", sReq); end
    for (int i = 1; i < 3; i++) begin
      cycle(1, 0, '0, 0);
      checks++; if (sReq !== 1'b0) begin failures++; $display("FAIL stall_req%0d: imem_req=%b required 0", i, sReq); end
      checks++; if (sPCD !== heldPC || sValid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d: PCD=%h valid=%b required %h/1", i, sPCD, sValid, heldPC); end
    end
    cycle(0, 0, '0, 0);
    checks++; if (sReq !== 1'b1) begin failures++; $display("FAIL stall_release_req: imem_req=%b required 1", sReq); end
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b1 || sPCD !== wrapAdd(heldPC)) begin failures++; $display("FAIL stall_buffered: PCD=%h valid=%b required %h/1", sPCD, sValid, wrapAdd(heldPC)); end
    cycle(0, 0, '0, 0);
    checks++; if (sPCD !== wrapAdd(wrapAdd(heldPC))) begin failures++; $display("FAIL stall_after: PCD=%h required %h", sPCD, wrapAdd(wrapAdd(heldPC))); end
  endtask

  task automatic test_redirect_pending();
    bit found;
    int nreq;
    logic [PC_W-1:0] r0, r1;
    latMin = 3; latMax = 3;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(0, 0, '0, 0);
      found = sReq;
    end
    checks++; if (!found) begin failures++; $display("FAIL redir_pend_setup: no request seen, required one"); end
    cycle(0, 1, 9'h040, 1);
    checks++; if (sReq !== 1'b0) begin failures++; $display("FAIL redir_pend_gate: imem_req=%b required 0", sReq); end
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b0) begin failures++; $display("FAIL redir_pend_bubble: ValidD=%b required 0", sValid); end
    nreq = 0; r0 = '0; r1 = '0;
    for (int i = 0; i < 20 && nreq < 2; i++) begin
      if (sReq === 1'b1) begin
        if (nreq == 0) r0 = sAddr; else r1 = sAddr;
        nreq++;
      end
      if (nreq < 2) cycle(0, 0, '0, 0);
    end
    checks++; if (nreq != 2 || r0 !== 9'h040 || r1 !== 9'h044) begin
      failures++; $display("FAIL redir_pend_target: %0d reqs %h %h required 040 044", nreq, r0, r1);
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit found, seen;
    latMin = 2; latMax = 2;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (respDue()) found = 1;
      else cycle(0, 0, '0, 0);
    end
    checks++; if (!found) begin failures++; $display("FAIL redir_same_setup: no response due, required one"); end
    cycle(0, 1, 9'h100, 1);
    cycle(0, 0, '0, 0);
    checks++; if (sReq !== 1'b1 || sAddr !== 9'h100) begin failures++; $display("FAIL redir_same_req: req=%b addr=%h required 1/100", sReq, sAddr); end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(0, 0, '0, 0);
      if (sValid === 1'b1) seen = 1;
    end
    checks++; if (!seen || sPCD !== 9'h100) begin failures++; $display("FAIL redir_same_first: PCD=%h seen=%b required 100/1", sPCD, seen); end
  endtask

  task automatic test_wrap();
    bit after1FC, wrapReq, wrapPlus;
    latMin = 1; latMax = 1;
    cycle(0, 1, 9'h1F8, 1);
    after1FC = 0; wrapReq = 0; wrapPlus = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, '0, 0);
      if (sReq === 1'b1) begin
        if (after1FC && !wrapReq) begin
          checks++; if (sAddr !== 9'h000) begin failures++; $display("FAIL wrap_req: addr=%h required 000", sAddr); end
          wrapReq = 1;
        end
        if (sAddr === 9'h1FC) after1FC = 1;
      end
      if (sValid === 1'b1 && sPCD === 9'h1FC && !wrapPlus) begin
        checks++; if (sPCPlus4 !== 9'h000) begin failures++; $display("FAIL wrap_pcplus4: %h required 000", sPCPlus4); end
        wrapPlus = 1;
      end
    end
    checks++; if (!wrapReq || !wrapPlus) begin failures++; $display("FAIL wrap_seen: req=%b plus4=%b required 1/1", wrapReq, wrapPlus); end
  endtask

  task automatic test_flush();
    logic [PC_W-1:0] fpc;
    latMin = 1; latMax = 1;
    repeat (3) cycle(0, 0, '0, 0);
    checks++; if (!respDue()) begin failures++; $display("FAIL flush_setup: no response due, required one"); end
    cycle(0, 0, '0, 1);
    fpc   = sPCD;
    expPC = wrapAdd(expPC);  // the instruction arriving in the flush cycle is lost
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b0) begin failures++; $display("FAIL flush_bubble: ValidD=%b required 0", sValid); end
    cycle(0, 0, '0, 0);
    checks++; if (sValid !== 1'b1 || sPCD !== wrapAdd(wrapAdd(fpc))) begin
      failures++; $display("FAIL flush_continue: PCD=%h valid=%b required %h/1", sPCD, sValid, wrapAdd(wrapAdd(fpc)));
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [PC_W-1:0] tgt;
    bit st, rd;
    int d0;
    latMin = 1; latMax = 4;
    for (int i = 0; i < 600; i++) begin
      r   = $urandom;
      tgt = r[8:0] & 9'h1FC;
      st  = ($urandom_range(99) < 30);
      rd  = ($urandom_range(99) < 6);
      cycle(st, rd, tgt, rd);
    end
    d0 = delivered;
    repeat (60) cycle(0, 0, '0, 0);
    checks++; if (delivered - d0 < 8) begin failures++; $display("FAIL random_progress: %0d delivered in 60 cycles required >= 8", delivered - d0); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int d0;
    latMin = 3; latMax = 3;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(0, 0, '0, 0);
      found = sReq;
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_setup: no request seen, required one"); end
    imem_valid = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 9'h0 || PCPlus4D !== 9'h0) begin
      failures++; $display("FAIL rstmid_immediate: req=%b valid=%b instr=%h pcd=%h p4=%h required 0/0/0/0/0", imem_req, ValidD, InstrD, PCD, PCPlus4D);
    end
    @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = memWord(pendAddr);
    @(negedge clk);
    #1;
    checks++; if (ValidD !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_late: valid=%b req=%b required 0/0", ValidD, imem_req); end
    @(negedge clk);
    imem_valid = 1'b0;
    rst = 1'b1;
    modelReset();
    cycle(0, 0, '0, 0);
    checks++; if (sReq !== 1'b1 || sAddr !== RESET_PC) begin failures++; $display("FAIL rstmid_first_req: req=%b addr=%h required 1/%h", sReq, sAddr, RESET_PC); end
    d0 = delivered;
    repeat (20) cycle(0, 0, '0, 0);
    checks++; if (delivered - d0 < 4) begin failures++; $display("FAIL rstmid_resume: %0d delivered required >= 4", delivered - d0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_same_cycle();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
